// File: rtl/l_class_oc_echodelay.sv
// l_class_oc_echodelay
//   Consumer stage between a one-entry request FIFO and the heard indication port.
//   Pops one word, holds it for DELAY cycles, then offers it together with a sequence
//   number on an ENA/RDY indication interface. A new word may be popped in the same
//   cycle the held word is delivered, giving one word per DELAY+1 cycles at full rate.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   in_first        FIFO head word
//   in_first__RDY   FIFO head valid
//   in_deq__RDY     FIFO deq permitted
//   in_deq__ENA     pop FIFO this cycle (combinational)
//   heard__RDY      sink can accept indication
//   heard__ENA      indication fires this cycle (combinational)
//   heard_v         echoed word (zero unless offering)
//   heard_seq       sequence number of the offered word (zero unless offering)
//   heard_count     total indications delivered, wraps modulo 2^CNT_W
//   busy            a word is held
module l_class_oc_echodelay #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DELAY = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in_first,
  input  logic             in_first__RDY,
  input  logic             in_deq__RDY,
  output logic             in_deq__ENA,
  input  logic             heard__RDY,
  output logic             heard__ENA,
  output logic [WIDTH-1:0] heard_v,
  output logic [CNT_W-1:0] heard_seq,
  output logic [CNT_W-1:0] heard_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  // Timer only needs to hold DELAY-1; keep at least one bit for DELAY of 0 or 1.
  localparam int unsigned TW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [TW-1:0] TLOAD = (DELAY == 0) ? '0 : TW'(DELAY - 1);
  localparam state_t POP_ST = (DELAY == 0) ? SEND : WAIT;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      data  <= '0;
      timer <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (in_deq__ENA) begin
        data  <= in_first;
        timer <= TLOAD;
      end else if (state == WAIT && timer != '0) begin
        timer <= timer - 1'b1;
      end
      if (heard__ENA) begin
        count <= count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    heard__ENA  = 1'b0;
    heard_v     = '0;
    heard_seq   = '0;
    in_deq__ENA = in_first__RDY & in_deq__RDY &
                  ((state == IDLE) | ((state == SEND) & heard__RDY));
    case (state)
      IDLE: begin
        if (in_deq__ENA) state_nxt = POP_ST;
      end
      WAIT: begin
        if (timer == '0) state_nxt = SEND;
      end
      SEND: begin
        heard__ENA = heard__RDY;
        heard_v    = data;
        heard_seq  = count;
        // Delivery and a refill pop can share a cycle; the refill wins the next state.
        if (heard__ENA) state_nxt = in_deq__ENA ? POP_ST : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign heard_count = count;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_l_class_oc_echodelay.sv
module tb_l_class_oc_echodelay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DELAY=3, CNT_W=16 instance
  logic [31:0] f3;
  logic        fr3, dr3, hr3, deq3, ena3, busy3;
  logic [31:0] v3;
  logic [15:0] seq3, cnt3;

  // DELAY=0 instance
  logic [31:0] f0;
  logic        fr0, dr0, hr0, deq0, ena0, busy0;
  logic [31:0] v0;
  logic [15:0] seq0, cnt0;

  // DELAY=0, CNT_W=4 instance
  logic [31:0] f4;
  logic        fr4, dr4, hr4, deq4, ena4, busy4;
  logic [31:0] v4;
  logic [3:0]  seq4, cnt4;

  l_class_oc_echodelay #(.WIDTH(32), .DELAY(3), .CNT_W(16)) u_d3 (
    .CLK(clk), .RST(rst), .in_first(f3), .in_first__RDY(fr3), .in_deq__RDY(dr3),
    .in_deq__ENA(deq3), .heard__RDY(hr3), .heard__ENA(ena3), .heard_v(v3),
    .heard_seq(seq3), .heard_count(cnt3), .busy(busy3));

  l_class_oc_echodelay #(.WIDTH(32), .DELAY(0), .CNT_W(16)) u_d0 (
    .CLK(clk), .RST(rst), .in_first(f0), .in_first__RDY(fr0), .in_deq__RDY(dr0),
    .in_deq__ENA(deq0), .heard__RDY(hr0), .heard__ENA(ena0), .heard_v(v0),
    .heard_seq(seq0), .heard_count(cnt0), .busy(busy0));

  l_class_oc_echodelay #(.WIDTH(32), .DELAY(0), .CNT_W(4)) u_c4 (
    .CLK(clk), .RST(rst), .in_first(f4), .in_first__RDY(fr4), .in_deq__RDY(dr4),
    .in_deq__ENA(deq4), .heard__RDY(hr4), .heard__ENA(ena4), .heard_v(v4),
    .heard_seq(seq4), .heard_count(cnt4), .busy(busy4));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] first;
    logic        frdy, drdy, hrdy;
    logic        e_deq, e_ena;
    logic [31:0] e_v;
    logic [15:0] e_seq, e_cnt;
    logic        e_busy;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [31:0] f, input logic fr, input logic dr,
                     input logic hr, input logic ed, input logic ee, input logic [31:0] ev,
                     input int es, input int ec, input logic eb);
    vec_t x;
    x.rst = r; x.first = f; x.frdy = fr; x.drdy = dr; x.hrdy = hr;
    x.e_deq = ed; x.e_ena = ee; x.e_v = ev;
    x.e_seq = 16'(es); x.e_cnt = 16'(ec); x.e_busy = eb;
    vt.push_back(x);
  endtask

  initial begin
    rst = 1'b1;
    {f3, fr3, dr3, hr3} = '0;
    {f0, fr0, dr0, hr0} = '0;
    {f4, fr4, dr4, hr4} = '0;
    repeat (2) @(posedge clk);

    // Reset state
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // Single word 0xDEADBEEF: pop, 3 hold cycles, indication 4 cycles after the pop
    add(0, 32'hDEADBEEF, 1, 1, 1,  1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1,  0, 1, 32'hDEADBEEF, 0, 0, 1);
    add(0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
    // Back-pressure: sink not ready for 10 cycles in SEND, head changes are ignored
    add(0, 32'h12345678, 1, 1, 0,  1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 32'hAAAA0000, 1, 1, 0,  0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) add(0, 32'hAAAA0000, 1, 1, 0,  0, 0, 32'h12345678, 1, 1, 1);
    add(0, 0, 0, 1, 1,  0, 1, 32'h12345678, 1, 1, 1);
    add(0, 0, 0, 1, 1,  0, 0, 0, 0, 2, 0);
    // Reset during WAIT holding 0x55: word dropped, count cleared
    add(0, 32'h55, 1, 1, 1,  1, 0, 0, 0, 2, 0);
    add(0, 0, 0, 1, 1,  0, 0, 0, 0, 2, 1);
    add(1, 0, 0, 1, 1,  0, 0, 0, 0, 2, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
    // Next word after reset handled normally, refill pop in the delivery cycle
    add(0, 32'h77, 1, 1, 1,  1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1);
    add(0, 32'h88, 1, 1, 1,  1, 1, 32'h77, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1,  0, 1, 32'h88, 1, 1, 1);
    add(0, 0, 0, 1, 1,  0, 0, 0, 0, 2, 0);
    // deq not permitted / head not valid: no pop
    add(0, 32'h99, 1, 0, 1,  0, 0, 0, 0, 2, 0);
    add(0, 32'h99, 0, 1, 1,  0, 0, 0, 0, 2, 0);

    foreach (vt[i]) begin
      @(posedge clk); #1;
      rst = vt[i].rst; f3 = vt[i].first; fr3 = vt[i].frdy; dr3 = vt[i].drdy; hr3 = vt[i].hrdy;
      @(negedge clk);
      check($sformatf("vec%0d_deq", i), 64'(deq3), 64'(vt[i].e_deq));
      check($sformatf("vec%0d_ena", i), 64'(ena3), 64'(vt[i].e_ena));
      check($sformatf("vec%0d_v", i), 64'(v3), 64'(vt[i].e_v));
      check($sformatf("vec%0d_seq", i), 64'(seq3), 64'(vt[i].e_seq));
      check($sformatf("vec%0d_cnt", i), 64'(cnt3), 64'(vt[i].e_cnt));
      check($sformatf("vec%0d_busy", i), 64'(busy3), 64'(vt[i].e_busy));
    end

    // Continuous supply of words 1..5 at DELAY=3, sink always ready
    @(posedge clk); #1; rst = 1'b1; fr3 = 1'b0;
    begin
      int idx, k, npop, last;
      idx = 0; k = 0; npop = 0; last = -1;
      for (int c = 0; c < 60 && k < 5; c++) begin
        @(posedge clk); #1;
        rst = 1'b0; f3 = 32'(idx + 1); fr3 = (idx < 5); dr3 = 1'b1; hr3 = 1'b1;
        @(negedge clk);
        if (deq3) begin
          if (last >= 0) check("t3_pop_gap", 64'(c - last), 64'd4);
          last = c; idx++; npop++;
        end
        if (ena3) begin
          check("t3_v", 64'(v3), 64'(k + 1));
          check("t3_seq", 64'(seq3), 64'(k));
          k++;
        end
      end
      check("t3_delivered", 64'(k), 64'd5);
      check("t3_pops", 64'(npop), 64'd5);
      @(posedge clk); #1; fr3 = 1'b0;
      @(negedge clk);
      check("t3_count", 64'(cnt3), 64'd5);
      check("t3_idle", 64'(busy3), 64'd0);
    end

    // DELAY=0: pop and indication every cycle after the first, data lags pop by one
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      f0 = 32'h100 + 32'(c); fr0 = (c < 8); dr0 = 1'b1; hr0 = 1'b1;
      @(negedge clk);
      check($sformatf("t4_deq%0d", c), 64'(deq0), 64'(c < 8));
      check($sformatf("t4_ena%0d", c), 64'(ena0), 64'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) begin
        check($sformatf("t4_v%0d", c), 64'(v0), 64'(32'h100 + 32'(c - 1)));
        check($sformatf("t4_seq%0d", c), 64'(seq0), 64'(c - 1));
      end
    end
    check("t4_count", 64'(cnt0), 64'd8);
    check("t4_idle", 64'(busy0), 64'd0);

    // CNT_W=4: 17 deliveries wrap the sequence 15 -> 0
    for (int c = 0; c < 19; c++) begin
      @(posedge clk); #1;
      f4 = 32'(c); fr4 = (c < 17); dr4 = 1'b1; hr4 = 1'b1;
      @(negedge clk);
      check($sformatf("t6_ena%0d", c), 64'(ena4), 64'(c >= 1 && c <= 17));
      if (c >= 1 && c <= 17) begin
        check($sformatf("t6_seq%0d", c), 64'(seq4), 64'((c - 1) % 16));
        check($sformatf("t6_v%0d", c), 64'(v4), 64'(c - 1));
      end
    end
    check("t6_count", 64'(cnt4), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
